// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control stage of the 8-entry FIFO.
// Arbitrates write/read requests, keeps head/tail pointers and occupancy,
// drives the write-decode and read-mux strobes/addresses, and reports
// one-cycle ack/error status from a registered state machine.
// Optional feature macro: FIFO_CTRL_ALMOST_FLAGS_EN adds almost_full and
// almost_empty outputs.
module fifo_ctrl #(
  parameter int AW    = 3,
  parameter int DEPTH = 2 ** AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          we,
  output logic [AW-1:0] wr_addr,
  output logic          re,
  output logic [AW-1:0] rd_addr,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err,
  output logic [AW:0]   data_count
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  ,
  output logic          almost_full,
  output logic          almost_empty
`endif
);

  typedef enum logic [2:0] {
    S_INIT,
    S_NO_OP,
    S_WRITE,
    S_WR_ERROR,
    S_READ,
    S_RD_ERROR
  } state_t;

  localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);
  localparam logic [AW:0] CountZero = '0;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;

  logic wrOnly;
  logic rdOnly;
  logic fullNow;
  logic emptyNow;

  assign fullNow  = (count_q == CountFull);
  assign emptyNow = (count_q == CountZero);

  // Request decode, strobe generation, next pointer/count and next FSM state.
  // Simultaneous read and write requests are treated as a no-op.
  always_comb begin
    wrOnly  = wr_en & ~rd_en & ~reset;
    rdOnly  = rd_en & ~wr_en & ~reset;
    we      = wrOnly & ~fullNow;
    re      = rdOnly & ~emptyNow;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = S_NO_OP;
    if (we) begin
      tail_d  = tail_q + AW'(1);
      count_d = count_q + (AW+1)'(1);
    end else if (re) begin
      head_d  = head_q + AW'(1);
      count_d = count_q - (AW+1)'(1);
    end
    if (wrOnly) begin
      state_d = fullNow ? S_WR_ERROR : S_WRITE;
    end else if (rdOnly) begin
      state_d = emptyNow ? S_RD_ERROR : S_READ;
    end
  end

  // Pointer and occupancy registers; reset discards all contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Status state machine; INIT is entered only through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign wr_addr    = tail_q;
  assign rd_addr    = head_q;
  assign full       = fullNow;
  assign empty      = emptyNow;
  assign data_count = count_q;

  assign wr_ack = (state_q == S_WRITE);
  assign wr_err = (state_q == S_WR_ERROR);
  assign rd_ack = (state_q == S_READ);
  assign rd_err = (state_q == S_RD_ERROR);

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  assign almost_full  = ~reset & (count_q == CountFull - (AW+1)'(1));
  assign almost_empty = ~reset & (count_q == (AW+1)'(1));
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: self-checking bench for fifo_ctrl using a reference model
// and a scoreboard queue of expected post-edge status.
module tb_fifo_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic          rd_en;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic          re;
  logic [AW-1:0] rd_addr;
  logic          full;
  logic          empty;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;
  logic [AW:0]   data_count;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  fifo_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .we(we),
    .wr_addr(wr_addr),
    .re(re),
    .rd_addr(rd_addr),
    .full(full),
    .empty(empty),
    .wr_ack(wr_ack),
    .wr_err(wr_err),
    .rd_ack(rd_ack),
    .rd_err(rd_err),
    .data_count(data_count)
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    ,
    .almost_full(almost_full),
    .almost_empty(almost_empty)
`endif
  );

  typedef struct {
    logic       wrAck;
    logic       wrErr;
    logic       rdAck;
    logic       rdErr;
    int         count;
  } expect_t;

  expect_t sbQueue[$];

  int checks;
  int errors;

  int mHead;
  int mTail;
  int mCount;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of requests, check same-cycle strobes/addresses against
  // the model, push expected status, then pop and compare after the edge.
  task automatic applyStimulus(input logic w, input logic r, input logic rst);
    logic    expWe;
    logic    expRe;
    expect_t e;
    expect_t got;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    reset = rst;
    #1;
    expWe = !rst && w && !r && (mCount != DEPTH);
    expRe = !rst && r && !w && (mCount != 0);
    checkOutput("we", 32'(we), 32'(expWe));
    checkOutput("re", 32'(re), 32'(expRe));
    if (!rst) begin
      checkOutput("wr_addr", 32'(wr_addr), 32'(mTail));
      checkOutput("rd_addr", 32'(rd_addr), 32'(mHead));
    end
    e.wrAck = 1'b0;
    e.wrErr = 1'b0;
    e.rdAck = 1'b0;
    e.rdErr = 1'b0;
    if (rst) begin
      mHead  = 0;
      mTail  = 0;
      mCount = 0;
    end else if (w && !r) begin
      if (mCount == DEPTH) begin
        e.wrErr = 1'b1;
      end else begin
        e.wrAck = 1'b1;
        mTail   = (mTail + 1) % DEPTH;
        mCount++;
      end
    end else if (r && !w) begin
      if (mCount == 0) begin
        e.rdErr = 1'b1;
      end else begin
        e.rdAck = 1'b1;
        mHead   = (mHead + 1) % DEPTH;
        mCount--;
      end
    end
    e.count = mCount;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    got = sbQueue.pop_front();
    checkOutput("wr_ack", 32'(wr_ack), 32'(got.wrAck));
    checkOutput("wr_err", 32'(wr_err), 32'(got.wrErr));
    checkOutput("rd_ack", 32'(rd_ack), 32'(got.rdAck));
    checkOutput("rd_err", 32'(rd_err), 32'(got.rdErr));
    checkOutput("data_count", 32'(data_count), 32'(got.count));
    checkOutput("full", 32'(full), 32'(got.count == DEPTH));
    checkOutput("empty", 32'(empty), 32'(got.count == 0));
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    checkOutput("almost_full", 32'(almost_full), 32'(!rst && got.count == DEPTH - 1));
    checkOutput("almost_empty", 32'(almost_empty), 32'(!rst && got.count == 1));
`endif
  endtask

  // Directed scenarios followed by a random mix.
  initial begin
    checks = 0;
    errors = 0;
    mHead  = 0;
    mTail  = 0;
    mCount = 0;
    reset  = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;

    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("tail_after_overflow", 32'(wr_addr), 32'd0);

    repeat (9) applyStimulus(1'b0, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("wrap_head", 32'(rd_addr), 32'd6);
    checkOutput("wrap_tail", 32'(wr_addr), 32'd2);

    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
